// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: ALU opcodes, shared-ALU arbiter FSM states and flag layout.
// The flag layout is used by alu_share_arbiter and the shared ALU it drives.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int ALU_FLAGS_W = 4;

    // Flag bit positions inside {vld,cry,ngt,zro}
    localparam int FLAG_VLD = 3;
    localparam int FLAG_CRY = 2;
    localparam int FLAG_NGT = 1;
    localparam int FLAG_ZRO = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past ptr (the last
// granted index) and wraps modulo NREQ; the first pending request wins.
// The pointer register itself lives in the instantiating module.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    // Scan requesters in round-robin order from ptr+1 and take the first pending one
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin arbitration.
// Each operation walks IDLE (accept) -> ISSUE (ALU driven) -> RESP (result held until consumed).
// Optional feature: define ALU_ARB_STATS_EN to add the per-requester wait_cnt output
// (16-bit saturating counters of cycles spent valid but not accepted).
module alu_share_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*4-1:0]      req_aluop,
    input  logic [NREQ*DW-1:0]     req_a,
    input  logic [NREQ*DW-1:0]     req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DW-1:0]          rsp_result,
    output logic [ALU_FLAGS_W-1:0] rsp_flags,
    output logic [3:0]             alu_op,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    input  logic [DW-1:0]          alu_result,
    input  logic [ALU_FLAGS_W-1:0] alu_flags
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]     wait_cnt
`endif
);

    localparam int IW = $clog2(NREQ);

    arb_state_t    state;
    arb_state_t    state_nxt;
    // Last granted index; doubles as the owner of the operation in flight
    logic [IW-1:0] ptr;
    logic [NREQ-1:0] grant;
    logic [IW-1:0] grant_idx;
    logic          any;
    logic          accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign accept = (state == IDLE) && any;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready[ptr]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant only while idle, response strobe only to the owner
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            IDLE:    req_ready = grant;
            RESP:    rsp_valid = NREQ'(1) << ptr;
            default: ;
        endcase
    end

    // Latch the winner's payload on accept; ALU inputs hold it until the next accept
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr    <= IW'(NREQ - 1);
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (accept) begin
            ptr    <= grant_idx;
            alu_op <= req_aluop[int'(grant_idx)*4 +: 4];
            alu_a  <= req_a[int'(grant_idx)*DW +: DW];
            alu_b  <= req_b[int'(grant_idx)*DW +: DW];
        end
    end

    // Capture the ALU output only on the ISSUE -> RESP edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (state == ISSUE) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt [NREQ];

    // Count cycles each requester is pending but not accepted, saturating at all-ones
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (RST)
                cnt[i] <= '0;
            else if (req_valid[i] && !req_ready[i] && (cnt[i] != 16'hFFFF))
                cnt[i] <= cnt[i] + 16'd1;
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        wait_cnt = '0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule
